fp12_add_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the 12-bit small-float adder datapath: 1 sign, 4-bit exponent, 7-bit fraction, hidden leading 1.
- Accepts an operand pair over a valid/ready handshake, then steps through ALIGN, ADD and NORM, and returns a registered result over a second valid/ready handshake.
- Normalization is iterative: one left shift per cycle, standing in for a leading-zero encoder.
- Sits between the operand issue logic and the result writeback of the FP unit.

---
 rtl/fp12_pkg.sv | 26 ++
 rtl/fp12_align_shifter.sv | 13 +
 rtl/fp12_add_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_fp12_add_seq_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fp12_pkg.sv
// Shared types and constants for the 12-bit small-float adder sequencer.
// Format: {sign, exp[3:0], frac[6:0]} with a hidden leading one; exp 0 means zero.
package fp12_pkg;

  localparam int EXP_W    = 4;
  localparam int MAN_W    = 7;
  localparam int MAX_EXP  = 15;
  localparam int SIGN_BIT = 11;
  localparam int EXP_MSB  = 10;
  localparam int EXP_LSB  = 7;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp12_t;

endpackage

// File: rtl/fp12_align_shifter.sv
// Combinational right shifter for the smaller significand during alignment.
// Bits shifted out are dropped; any amount of 8 or more yields zero.
module fp12_align_shifter (
  input  logic [7:0] sig,
  input  logic [3:0] amt,
  output logic [7:0] shifted
);

  always_comb begin
    shifted = amt[3] ? 8'h00 : (sig >> amt[2:0]);
  end

endmodule

// File: rtl/fp12_add_seq_ctrl.sv
// Multi-cycle sequencer for the 12-bit float adder: accept, align, add,
// iterative normalize (one left shift per cycle), then hold the result until taken.
import fp12_pkg::*;

module fp12_add_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] x,
  input  logic [11:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] z,
  output logic        ovf,
  output logic        unf,
  output logic        busy
);

  state_t state, state_nx;

  fp12_t      xr, yr, gop, lop, zr;
  logic       x_big, zero_op, res_sign, sub, ovf_r, unf_r;
  logic [3:0] shamt, ge;
  logic [7:0] lsig_sh, gsig, lsig;
  logic [8:0] sum;

  always_comb begin
    x_big   = {xr.exp, xr.frac} >= {yr.exp, yr.frac};
    gop     = x_big ? xr : yr;
    lop     = x_big ? yr : xr;
    shamt   = gop.exp - lop.exp;
    zero_op = (xr.exp == 4'd0) || (yr.exp == 4'd0);
  end

  fp12_align_shifter u_shift (
    .sig     ({1'b1, lop.frac}),
    .amt     (shamt),
    .shifted (lsig_sh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A zero operand skips ADD: ALIGN preloads it as an already-normalized sum
  // so NORM passes it through unchanged, giving the two-cycle shortcut.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (in_valid) state_nx = ALIGN;
      ALIGN: state_nx = zero_op ? NORM : ADD;
      ADD:   state_nx = NORM;
      NORM:  if (sum == 9'd0 || sum[8] || sum[7] || ge == 4'd1) state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    z         = zr;
    ovf       = ovf_r;
    unf       = unf_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr       <= '0;
      yr       <= '0;
      gsig     <= '0;
      lsig     <= '0;
      ge       <= '0;
      res_sign <= 1'b0;
      sub      <= 1'b0;
      sum      <= '0;
      zr       <= '0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr <= x;
            yr <= y;
          end
        end
        ALIGN: begin
          if (xr.exp == 4'd0 && yr.exp == 4'd0) begin
            sum      <= '0;
            ge       <= '0;
            res_sign <= 1'b0;
          end else if (xr.exp == 4'd0) begin
            sum      <= {2'b01, yr.frac};
            ge       <= yr.exp;
            res_sign <= yr.sign;
          end else if (yr.exp == 4'd0) begin
            sum      <= {2'b01, xr.frac};
            ge       <= xr.exp;
            res_sign <= xr.sign;
          end else begin
            gsig     <= {1'b1, gop.frac};
            lsig     <= lsig_sh;
            ge       <= gop.exp;
            res_sign <= gop.sign;
            sub      <= xr.sign ^ yr.sign;
          end
        end
        ADD: begin
          sum <= sub ? ({1'b0, gsig} - {1'b0, lsig}) : ({1'b0, gsig} + {1'b0, lsig});
        end
        NORM: begin
          if (sum == 9'd0) begin
            zr <= '0;
          end else if (sum[8]) begin
            if (ge == 4'(MAX_EXP)) begin
              zr    <= {res_sign, 4'hF, 7'h7F};
              ovf_r <= 1'b1;
            end else begin
              zr <= {res_sign, ge + 4'd1, sum[7:1]};
            end
          end else if (sum[7]) begin
            zr <= {res_sign, ge, sum[6:0]};
          end else if (ge == 4'd1) begin
            zr    <= {res_sign, 11'd0};
            unf_r <= 1'b1;
          end else begin
            sum <= {sum[7:0], 1'b0};
            ge  <= ge - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp12_add_seq_ctrl.sv
// Self-checking bench for fp12_add_seq_ctrl: directed test-plan cases, reset
// mid-operation, and randomized operands against an integer arithmetic model.
module tb_fp12_add_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] x;
  logic [11:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] z;
  logic        ovf;
  logic        unf;
  logic        busy;

  int tests;
  int fails;

  fp12_add_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .ovf       (ovf),
    .unf       (unf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: real significand arithmetic, normalization found by counting
  // how far the sum must move to reach the hidden-bit position.
  task automatic model(input logic [11:0] a, input logic [11:0] b,
                       output logic [11:0] rz, output logic rovf, output logic runf,
                       output int lat);
    int ea, eb, fa, fb, sg, sl, eg, el, d, ls, s, k;
    logic sgn;
    rovf = 1'b0;
    runf = 1'b0;
    ea = int'(a[10:7]);
    eb = int'(b[10:7]);
    fa = int'(a[6:0]);
    fb = int'(b[6:0]);
    if (ea == 0 || eb == 0) begin
      lat = 2;
      if (ea == 0 && eb == 0) rz = 12'h000;
      else if (ea == 0)       rz = b;
      else                    rz = a;
      return;
    end
    if (ea * 128 + fa >= eb * 128 + fb) begin
      sg = 128 + fa; eg = ea; sl = 128 + fb; el = eb; sgn = a[11];
    end else begin
      sg = 128 + fb; eg = eb; sl = 128 + fa; el = ea; sgn = b[11];
    end
    d  = eg - el;
    ls = (d >= 8) ? 0 : sl / (1 << d);
    s  = (a[11] == b[11]) ? sg + ls : sg - ls;
    lat = 3;
    if (s == 0) begin
      rz = 12'h000;
    end else if (s >= 256) begin
      if (eg == 15) begin
        rz = {sgn, 11'h7FF};
        rovf = 1'b1;
      end else begin
        rz = {sgn, 4'(eg + 1), 7'((s / 2) % 128)};
      end
    end else begin
      k = 0;
      while ((s << k) < 128) k++;
      if (eg - k >= 1) begin
        rz  = {sgn, 4'(eg - k), 7'((s << k) % 128)};
        lat = 3 + k;
      end else begin
        rz   = {sgn, 11'h000};
        runf = 1'b1;
        lat  = 3 + eg - 1;
      end
    end
  endtask

  // Runs one operation from the IDLE state; hold = cycles of backpressure in DONE.
  task automatic applyStimulus(input logic [11:0] a, input logic [11:0] b, input int hold,
                               input logic [11:0] ez, input logic eo, input logic eu,
                               input int el);
    int lat;
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    x = a;
    y = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 12'($urandom);
    y = 12'($urandom);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      x = 12'($urandom);
      y = 12'($urandom);
    end
    checkOutput("out_valid_seen", 32'(out_valid), 32'd1);
    checkOutput("latency", 32'(lat), 32'(el));
    checkOutput("z", 32'(z), 32'(ez));
    checkOutput("ovf", 32'(ovf), 32'(eo));
    checkOutput("unf", 32'(unf), 32'(eu));
    checkOutput("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_z", 32'(z), 32'(ez));
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("valid_drop", 32'(out_valid), 32'd0);
    checkOutput("in_ready_after", 32'(in_ready), 32'd1);
    checkOutput("ovf_clear", 32'(ovf), 32'd0);
    checkOutput("unf_clear", 32'(unf), 32'd0);
  endtask

  task automatic randomOp(input logic [11:0] a, input logic [11:0] b, input int hold);
    logic [11:0] ez;
    logic eo, eu;
    int el;
    model(a, b, ez, eo, eu, el);
    applyStimulus(a, b, hold, ez, eo, eu, el);
  endtask

  initial begin
    logic [11:0] ra, rb;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;

    repeat (2) @(posedge clk); #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_z", 32'(z), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_unf", 32'(unf), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(12'h380, 12'h380, 0, 12'h400, 1'b0, 1'b0, 3);
    applyStimulus(12'h380, 12'hB80, 0, 12'h000, 1'b0, 1'b0, 3);
    applyStimulus(12'h3C0, 12'hB80, 0, 12'h300, 1'b0, 1'b0, 4);
    applyStimulus(12'h7FF, 12'h7FF, 0, 12'h7FF, 1'b1, 1'b0, 3);
    applyStimulus(12'h000, 12'h3C0, 0, 12'h3C0, 1'b0, 1'b0, 2);
    applyStimulus(12'h3C0, 12'h000, 0, 12'h3C0, 1'b0, 1'b0, 2);
    applyStimulus(12'h005, 12'h803, 0, 12'h000, 1'b0, 1'b0, 2);
    applyStimulus(12'h080, 12'h8FF, 0, 12'h800, 1'b0, 1'b1, 3);
    applyStimulus(12'h380, 12'h380, 5, 12'h400, 1'b0, 1'b0, 3);

    x = 12'h3C0;
    y = 12'hB80;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midop_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midop_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midop_busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(12'h380, 12'h380, 0, 12'h400, 1'b0, 1'b0, 3);

    for (int i = 0; i < 60; i++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      if ($urandom_range(0, 9) == 0) ra[10:7] = 4'd0;
      if ($urandom_range(0, 9) == 0) rb[10:7] = 4'd0;
      if ($urandom_range(0, 3) == 0) rb[10:7] = ra[10:7];
      if ($urandom_range(0, 5) == 0) ra[10:7] = 4'($urandom_range(1, 2));
      randomOp(ra, rb, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
